// File: rtl/alu_job_pkg.sv
// Shared types and constants for the ALU job bus initiator.
package alu_job_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_REQ,
    S_WR_A,
    S_WR_B,
    S_WR_OP,
    S_WR_GO,
    S_POLL_A,
    S_POLL_D,
    S_RD_LO,
    S_RD_HI,
    S_RD_END,
    S_WR_CLR,
    S_WR_R0,
    S_WR_R1,
    S_DONE
  } state_t;

  localparam logic [7:0] OFS_OPA  = 8'd0;
  localparam logic [7:0] OFS_OPB  = 8'd1;
  localparam logic [7:0] OFS_OPC  = 8'd2;
  localparam logic [7:0] OFS_CTRL = 8'd3;
  localparam logic [7:0] OFS_LO   = 8'd4;
  localparam logic [7:0] OFS_HI   = 8'd5;
  localparam logic [7:0] OFS_STAT = 8'd6;

  localparam logic [31:0] CTRL_GO  = 32'd1;
  localparam logic [31:0] CTRL_CLR = 32'd0;

endpackage

// File: rtl/alu_job_master_bus_master_port.sv
// Registered bus master drive; a command takes effect on the bus one edge
// after it is issued, and `accepted` flags the grant-qualified transfer.
module bus_master_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_req,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              M_grant,
  output logic              M_req,
  output logic              M_wr,
  output logic [ADDR_W-1:0] M_addr,
  output logic [DATA_W-1:0] M_dout,
  output logic              accepted
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      M_req  <= 1'b0;
      M_wr   <= 1'b0;
      M_addr <= '0;
      M_dout <= '0;
    end else begin
      M_req  <= cmd_req;
      M_wr   <= cmd_wr;
      M_addr <= cmd_addr;
      M_dout <= cmd_data;
    end
  end

  assign accepted = M_req & M_grant;

endmodule

// File: rtl/alu_job_master.sv
// Runs one ALU job over the system bus: load operands, poll status, fetch the
// 64-bit result, store it to RAM and report it.
module alu_job_master
  import alu_job_pkg::*;
#(
  parameter logic [7:0]  ALU_BASE   = 8'h00,
  parameter logic [7:0]  RAM_BASE   = 8'h20,
  parameter logic [15:0] POLL_LIMIT = 16'd1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [3:0]  opcode,
  input  logic [4:0]  dst_idx,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [63:0] result,
  output logic        M_req,
  output logic        M_wr,
  output logic [7:0]  M_addr,
  output logic [31:0] M_dout,
  input  logic        M_grant,
  input  logic [31:0] M_din
);

  localparam int DATA_W = 32;

  state_t            state, state_nx;
  logic              cmd_req, cmd_wr, accepted;
  logic [7:0]        cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic [DATA_W-1:0] a_q, b_q, lo_q, hi_q;
  logic [3:0]        opc_q;
  logic [4:0]        idx_q;
  logic [15:0]       poll_cnt;
  logic              timeout, cap_lo, poll_expired;

  assign poll_expired = (state == S_POLL_D) && !M_din[0] && (poll_cnt == POLL_LIMIT);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start)    state_nx = S_REQ;
      S_REQ:    if (accepted) state_nx = S_WR_A;
      S_WR_A:   if (accepted) state_nx = S_WR_B;
      S_WR_B:   if (accepted) state_nx = S_WR_OP;
      S_WR_OP:  if (accepted) state_nx = S_WR_GO;
      S_WR_GO:  if (accepted) state_nx = S_POLL_A;
      S_POLL_A: if (accepted) state_nx = S_POLL_D;
      S_POLL_D: begin
        if (M_din[0])          state_nx = S_RD_LO;
        else if (poll_expired) state_nx = S_WR_CLR;
        else                   state_nx = S_POLL_A;
      end
      S_RD_LO:  if (accepted) state_nx = S_RD_HI;
      S_RD_HI:  if (accepted) state_nx = S_RD_END;
      S_RD_END: state_nx = S_WR_CLR;
      S_WR_CLR: if (accepted) state_nx = timeout ? S_DONE : S_WR_R0;
      S_WR_R0:  if (accepted) state_nx = S_WR_R1;
      S_WR_R1:  if (accepted) state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Command for the state being entered; capture-only states keep the bus
  // owned with a side-effect-free read of the opA register.
  always_comb begin
    cmd_req  = 1'b0;
    cmd_wr   = 1'b0;
    cmd_addr = ALU_BASE + OFS_OPA;
    cmd_data = '0;
    case (state_nx)
      S_REQ, S_POLL_D, S_RD_END: cmd_req = 1'b1;
      S_WR_A:   begin cmd_req = 1'b1; cmd_wr = 1'b1; cmd_data = a_q; end
      S_WR_B:   begin cmd_req = 1'b1; cmd_wr = 1'b1; cmd_addr = ALU_BASE + OFS_OPB; cmd_data = b_q; end
      S_WR_OP:  begin cmd_req = 1'b1; cmd_wr = 1'b1; cmd_addr = ALU_BASE + OFS_OPC; cmd_data = {28'b0, opc_q}; end
      S_WR_GO:  begin cmd_req = 1'b1; cmd_wr = 1'b1; cmd_addr = ALU_BASE + OFS_CTRL; cmd_data = CTRL_GO; end
      S_POLL_A: begin cmd_req = 1'b1; cmd_addr = ALU_BASE + OFS_STAT; end
      S_RD_LO:  begin cmd_req = 1'b1; cmd_addr = ALU_BASE + OFS_LO; end
      S_RD_HI:  begin cmd_req = 1'b1; cmd_addr = ALU_BASE + OFS_HI; end
      S_WR_CLR: begin cmd_req = 1'b1; cmd_wr = 1'b1; cmd_addr = ALU_BASE + OFS_CTRL; cmd_data = CTRL_CLR; end
      S_WR_R0:  begin cmd_req = 1'b1; cmd_wr = 1'b1; cmd_addr = RAM_BASE + {3'b000, idx_q}; cmd_data = lo_q; end
      S_WR_R1:  begin cmd_req = 1'b1; cmd_wr = 1'b1; cmd_addr = RAM_BASE + {3'b000, idx_q + 5'd1}; cmd_data = hi_q; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      poll_cnt <= '0;
      timeout  <= 1'b0;
      cap_lo   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      result   <= '0;
    end else begin
      state  <= state_nx;
      busy   <= (state_nx != S_IDLE);
      done   <= (state_nx == S_DONE);
      cap_lo <= (state == S_RD_LO) && accepted;
      if (state == S_IDLE && start) begin
        poll_cnt <= '0;
        timeout  <= 1'b0;
      end
      if (state == S_POLL_A && accepted) poll_cnt <= poll_cnt + 16'd1;
      if (poll_expired) timeout <= 1'b1;
      if (state_nx == S_DONE) begin
        error <= timeout;
        if (!timeout) result <= {hi_q, lo_q};
      end
    end
  end

  // Lo data only follows an accepted lo read; a stalled RD_HI must not
  // recapture whatever M_din carries later.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      a_q   <= op_a;
      b_q   <= op_b;
      opc_q <= opcode;
      idx_q <= dst_idx;
    end
    if (state == S_RD_HI && cap_lo) lo_q <= M_din;
    if (state == S_RD_END) hi_q <= M_din;
  end

  bus_master_port #(.DATA_W(DATA_W), .ADDR_W(8)) u_port (
    .clk      (clk),
    .reset_n  (reset_n),
    .cmd_req  (cmd_req),
    .cmd_wr   (cmd_wr),
    .cmd_addr (cmd_addr),
    .cmd_data (cmd_data),
    .M_grant  (M_grant),
    .M_req    (M_req),
    .M_wr     (M_wr),
    .M_addr   (M_addr),
    .M_dout   (M_dout),
    .accepted (accepted)
  );

endmodule
